// File: rtl/fib_job_arbiter.sv
// fib_job_arbiter: round-robin front end that shares one Fibonacci sequencer among NREQ clients.
// Optional macro FIB_TIMEOUT_EN adds a TIMEOUT_CYC watchdog on RUN that returns an error response.
module fib_job_arbiter #(
    parameter int NREQ        = 2,
    parameter int CNT_W       = 8,
    parameter int RES_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*CNT_W-1:0] req_count,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [RES_W-1:0]      rsp_result,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  dp_start,
    output logic [CNT_W-1:0]      dp_count,
    input  logic                  dp_done,
    input  logic [RES_W-1:0]      dp_result
);
    // state | meaning
    // IDLE  | no job; round-robin arbitration, grant strobed on req_ready
    // RUN   | sequencer started, waiting for dp_done (or watchdog expiry)
    // RESP  | result held on rsp_valid[id] until the owner takes it

    localparam int ID_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("fib_job_arbiter: NREQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] winner;
    logic            win_found;
    logic [CNT_W-1:0] cnt_sel;
    logic            first_run;
    logic            done_ok;
    logic            expired;

    // Search starts one past the last served requester, so nobody waits more than NREQ-1 jobs.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = ID_W'((int'(ptr) + off) % NREQ);
            if (!win_found && req_valid[idx]) begin
                winner    = idx;
                win_found = 1'b1;
            end
        end
    end

    assign cnt_sel = req_count[winner*CNT_W +: CNT_W];
    assign done_ok = dp_done && !first_run;

`ifdef FIB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] tmr;
    logic             err_q;

    assign expired = (tmr == '0);
    assign rsp_err = err_q;

    // Down-counter loaded on accept; terminal count in a RUN cycle means TIMEOUT_CYC cycles elapsed.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr   <= '0;
            err_q <= 1'b0;
        end else if (state == IDLE && win_found) begin
            tmr   <= TMR_W'(TIMEOUT_CYC - 1);
            err_q <= 1'b0;
        end else if (state == RUN) begin
            if (!done_ok && expired) begin
                err_q <= 1'b1;
            end else if (!expired) begin
                tmr <= tmr - 1'b1;
            end
        end
    end
`else
    assign expired = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_found) state_nxt = (cnt_sel == '0) ? RESP : RUN;
            RUN:     if (done_ok || expired) state_nxt = RESP;
            RESP:    if (rsp_ready[id]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (state != IDLE);
        if (state == IDLE && win_found && !rst) req_ready[winner] = 1'b1;
        if (state == RESP) rsp_valid[id] = 1'b1;
    end

    // A zero count never starts the sequencer; the job goes straight to RESP with a zero result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= ID_W'(NREQ - 1);
            id         <= '0;
            first_run  <= 1'b0;
            dp_start   <= 1'b0;
            dp_count   <= '0;
            rsp_result <= '0;
        end else begin
            first_run <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        id         <= winner;
                        dp_count   <= cnt_sel;
                        dp_start   <= (cnt_sel != '0);
                        first_run  <= 1'b1;
                        rsp_result <= '0;
                    end
                end
                RUN: begin
                    if (done_ok) begin
                        rsp_result <= dp_result;
                        dp_start   <= 1'b0;
                    end else if (expired) begin
                        rsp_result <= '0;
                        dp_start   <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready[id]) ptr <= id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_job_arbiter.sv
// Scoreboard bench for fib_job_arbiter: random requesters, a behavioural sequencer and a queue-based checker.
// Build with +define+FIB_TIMEOUT_EN to exercise the watchdog path.
module tb_fib_job_arbiter;
    localparam int NREQ  = 2;
    localparam int CNT_W = 8;
    localparam int RES_W = 16;
    localparam int TOC   = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*CNT_W-1:0] req_count;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [RES_W-1:0]      rsp_result;
    logic                  rsp_err;
    logic                  busy;
    logic                  dp_start;
    logic [CNT_W-1:0]      dp_count;
    logic                  dp_done;
    logic [RES_W-1:0]      dp_result;

    fib_job_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .RES_W(RES_W), .TIMEOUT_CYC(TOC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_count(req_count),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
        .dp_start(dp_start), .dp_count(dp_count), .dp_done(dp_done), .dp_result(dp_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               id;
        int               count;
        logic [RES_W-1:0] result;
        logic             err;
        int               rsp_cyc;
        int               hi;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   model_last  = NREQ - 1;
    int   next_delay  = 0;
    int   cur_delay   = 2;
    int   run_n       = 0;
    int   force_cnt[NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sequencer result for count n: F(n+1) with F(1)=F(2)=1, truncated to the result width.
    function automatic logic [RES_W-1:0] seq_result(input int n);
        logic [RES_W-1:0] a, b, t;
        a = 0;
        b = 1;
        for (int k = 0; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural sequencer: dp_done rises after cur_delay cycles of dp_start; result is junk until then.
    initial begin
        dp_done   = 1'b0;
        dp_result = '0;
        forever begin
            @(negedge clk);
            if (dp_start) run_n++;
            else run_n = 0;
            dp_done   = dp_start && (run_n >= cur_delay);
            dp_result = dp_done ? seq_result(int'(dp_count)) : RES_W'($urandom);
        end
    end

    // One cycle of stimulus; on a grant the model checks the winner and pushes the expected response.
    task automatic step(input int p_req, input int rmode);
        int   w;
        int   c;
        int   d;
        int   m;
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (force_cnt[i] >= 0) begin
                req_valid[i] = 1'b1;
                req_count[i*CNT_W +: CNT_W] = CNT_W'(force_cnt[i]);
                force_cnt[i] = -1;
            end else if (!req_valid[i] && int'($urandom_range(99)) < p_req) begin
                req_valid[i] = 1'b1;
                req_count[i*CNT_W +: CNT_W] = ($urandom_range(4) == 0) ? '0 : CNT_W'($urandom_range(1, 30));
            end
        end
        rsp_ready = (rmode == 0) ? NREQ'($urandom) : (rmode == 1) ? '1 : '0;
        #1;
        if (req_ready != '0) begin
            w = -1;
            for (int off = 1; off <= NREQ; off++) begin
                if (w < 0 && req_valid[(model_last + off) % NREQ]) w = (model_last + off) % NREQ;
            end
            check("grant", req_ready, (w >= 0) ? (64'd1 << w) : 64'd0);
            if (w >= 0) begin
                c = int'(req_count[w*CNT_W +: CNT_W]);
                d = (next_delay > 0) ? next_delay : int'($urandom_range(1, 12));
                cur_delay = d;
                m = (d < 2) ? 2 : d;
                e.err = 1'b0;
                e.result = seq_result(c);
`ifdef FIB_TIMEOUT_EN
                if (m > TOC) begin
                    m = TOC;
                    e.err = 1'b1;
                    e.result = '0;
                end
`endif
                if (c == 0) begin
                    m = 0;
                    e.err = 1'b0;
                    e.result = '0;
                end
                e.id = w;
                e.count = c;
                e.rsp_cyc = cyc + 1 + m;
                e.hi = m;
                sbq.push_back(e);
                model_last = w;
                @(posedge clk);
                #1;
                req_valid[w] = 1'b0;
            end
        end
    endtask

    // Monitor: per-cycle invariants plus pop-and-compare on each response handshake.
    initial begin
        int   hi_cnt;
        logic shown;
        hi_cnt = 0;
        shown  = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hi_cnt = 0;
                shown  = 1'b0;
            end else begin
                check("busy", busy, dp_start || (rsp_valid != '0));
                if (dp_start) begin
                    hi_cnt++;
                    if (sbq.size() > 0) check("dp_count", dp_count, sbq[0].count);
                end
                if (rsp_valid != '0) begin
                    check("req_ready_in_resp", req_ready, 0);
                    check("dp_start_in_resp", dp_start, 0);
                    if (sbq.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        if (!shown) begin
                            check("rsp_latency_cycle", cyc, sbq[0].rsp_cyc);
                            check("dp_start_cycles", hi_cnt, sbq[0].hi);
                        end
                        check("rsp_valid", rsp_valid, 64'd1 << sbq[0].id);
                        check("rsp_result", rsp_result, sbq[0].result);
                        check("rsp_err", rsp_err, sbq[0].err);
                        shown = 1'b1;
                        if (rsp_ready[sbq[0].id]) begin
                            void'(sbq.pop_front());
                            hi_cnt = 0;
                            shown  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dp_start"}, dp_start, 0);
        check({tag, "_dp_count"}, dp_count, 0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        #1;
        check_all_zero(tag);
        sbq.delete();
        model_last = NREQ - 1;
        rst = 1'b0;
    endtask

    initial begin
        int budget;
        rst       = 1'b1;
        req_valid = '0;
        req_count = '0;
        rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) force_cnt[i] = -1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // count=5, sequencer done after 20 cycles
        force_cnt[0] = 5;
        next_delay   = 20;
        repeat (30) step(0, 1);

        // count=0 bypass on requester 1
        force_cnt[1] = 0;
        next_delay   = 0;
        repeat (5) step(0, 1);

        // both requesters continuously pending: grants alternate
        repeat (60) step(100, 1);
        repeat (40) step(0, 1);

        // response held off while the other requester is pending
        force_cnt[0] = 3;
        force_cnt[1] = 4;
        next_delay   = 4;
        repeat (25) step(0, 2);
        repeat (40) step(0, 1);

        next_delay = 0;
        repeat (1500) step(30, 0);
        budget = 400;
        while (sbq.size() > 0 && budget > 0) begin
            step(0, 1);
            budget--;
        end
        check("drain_timeout", sbq.size(), 0);

        // reset in the middle of a job; next grant must go to requester 0
        force_cnt[1] = 10;
        next_delay   = 12;
        repeat (5) step(0, 1);
        check("midrun_dp_start", dp_start, 1);
        pulse_reset("midrun_reset");
        force_cnt[0] = 2;
        force_cnt[1] = 2;
        next_delay   = 3;
        step(0, 1);
        check("post_reset_winner", sbq.size() > 0 ? sbq[0].id : -1, 0);
        repeat (40) step(0, 1);

        // sequencer that never finishes
        force_cnt[1] = 7;
        next_delay   = 1000;
`ifdef FIB_TIMEOUT_EN
        repeat (40) step(0, 1);
        check("timeout_drained", sbq.size(), 0);
`else
        repeat (40) step(0, 1);
        check("stall_busy", busy, 1);
        check("stall_dp_start", dp_start, 1);
        pulse_reset("stall_reset");
`endif
        next_delay = 0;
        repeat (5) step(0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
